// File: rtl/led_shift_sched.sv
// Sequencer for the LED shift register. It divides the clock into shift strobes, picks
// the shift direction for rotate or bounce mode, tracks the lit LED and pulses a reload.
module led_shift_sched #(
  parameter int          NB_LEDS    = 4,
  parameter int          NB_POS     = 2,
  parameter int          NB_COUNTER = 32,
  parameter int unsigned RATE0      = 100_000_000,
  parameter int unsigned RATE1      = 50_000_000,
  parameter int unsigned RATE2      = 25_000_000,
  parameter int unsigned RATE3      = 12_500_000
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [1:0]        i_sel,
  input  logic              i_mode,
  input  logic              i_dir,
  input  logic              i_clear,
  output logic              o_valid,
  output logic              o_dir,
  output logic              o_load,
  output logic [NB_POS-1:0] o_pos,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN_L = 2'd1, RUN_R = 2'd2} state_t;

  localparam logic [NB_POS-1:0] POS_LAST = NB_POS'(NB_LEDS - 1);

  // Rates of 0 and 1 both mean one strobe every cycle, so the terminal count is 0.
  localparam logic [NB_COUNTER-1:0] LAST0 = NB_COUNTER'((RATE0 <= 1) ? 0 : RATE0 - 1);
  localparam logic [NB_COUNTER-1:0] LAST1 = NB_COUNTER'((RATE1 <= 1) ? 0 : RATE1 - 1);
  localparam logic [NB_COUNTER-1:0] LAST2 = NB_COUNTER'((RATE2 <= 1) ? 0 : RATE2 - 1);
  localparam logic [NB_COUNTER-1:0] LAST3 = NB_COUNTER'((RATE3 <= 1) ? 0 : RATE3 - 1);

  state_t                state, state_nx;
  logic [NB_COUNTER-1:0] count, count_nx, last;
  logic [NB_POS-1:0]     pos_nx, pos_up, pos_dn;
  logic                  valid_nx, dir_nx, load_nx;
  logic [1:0]            sel_prev;
  logic                  clear_prev;

  always_comb begin
    case (i_sel)
      2'd0:    last = LAST0;
      2'd1:    last = LAST1;
      2'd2:    last = LAST2;
      default: last = LAST3;
    endcase
  end

  assign pos_up = (o_pos == POS_LAST) ? '0 : o_pos + 1'b1;
  assign pos_dn = (o_pos == '0) ? POS_LAST : o_pos - 1'b1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx = state;
    count_nx = count;
    pos_nx   = o_pos;
    valid_nx = 1'b0;
    dir_nx   = o_dir;
    load_nx  = 1'b0;

    if (i_clear) begin
      pos_nx   = '0;
      count_nx = '0;
      load_nx  = ~clear_prev;
      state_nx = i_enable ? RUN_L : IDLE;
    end else if (!i_enable) begin
      state_nx = IDLE;
      count_nx = '0;
    end else if (state == IDLE) begin
      state_nx = (!i_mode && i_dir) ? RUN_R : RUN_L;
      count_nx = '0;
    end else if (i_sel != sel_prev) begin
      count_nx = '0;
    end else if (count < last) begin
      count_nx = count + 1'b1;
    end else begin
      count_nx = '0;
      if (!i_mode) begin
        valid_nx = 1'b1;
        dir_nx   = i_dir;
        pos_nx   = i_dir ? pos_dn : pos_up;
        state_nx = i_dir ? RUN_R : RUN_L;
      end else if (state == RUN_L) begin
        // An end LED reached by a mode switch costs one silent tick to turn around.
        if (NB_LEDS > 1 && o_pos == POS_LAST) begin
          state_nx = RUN_R;
        end else begin
          valid_nx = 1'b1;
          dir_nx   = 1'b0;
          pos_nx   = pos_up;
          if (pos_up == POS_LAST) state_nx = RUN_R;
        end
      end else begin
        if (NB_LEDS > 1 && o_pos == '0) begin
          state_nx = RUN_L;
        end else begin
          valid_nx = 1'b1;
          dir_nx   = 1'b1;
          pos_nx   = pos_dn;
          if (pos_dn == '0) state_nx = RUN_L;
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      count      <= '0;
      o_pos      <= '0;
      o_valid    <= 1'b0;
      o_dir      <= 1'b0;
      o_load     <= 1'b0;
      sel_prev   <= '0;
      clear_prev <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      o_pos      <= pos_nx;
      o_valid    <= valid_nx;
      o_dir      <= dir_nx;
      o_load     <= load_nx;
      sel_prev   <= i_sel;
      clear_prev <= i_clear;
    end
  end

  assign o_state = state;

endmodule
